// File: rtl/cocpu_mailbox_pkg.sv
// Shared constants for the co-CPU to host mailbox: register offsets, window base, bit positions.
package cocpu_mailbox_pkg;

    localparam logic [1:0] OFS_DATA    = 2'd0;
    localparam logic [1:0] OFS_STATUS  = 2'd1;
    localparam logic [1:0] OFS_CONTROL = 2'd2;

    localparam logic [5:0] WIN_BASE = 6'b111110;

    localparam int STAT_IRQ  = 7;
    localparam int STAT_OVF  = 6;
    localparam int STAT_FULL = 5;

    localparam int CTRL_IRQEN  = 0;
    localparam int CTRL_FLUSH  = 1;
    localparam int CTRL_CLROVF = 2;

endpackage

// File: rtl/cocpu_host_mailbox_fifo.sv
// Synchronous DEPTH x 8 first-word-fall-through FIFO with flush; head valid the cycle after a push.
// Backpressure: push while full is dropped unless a pop frees the slot the same cycle; pop while empty is ignored.
module mailbox_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [7:0]    push_dat,
    input  logic          pop,
    input  logic          flush,
    output logic [7:0]    head_dat,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty
);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign head_dat = mem[rd_ptr];

    // A pop on a full FIFO frees the slot the concurrent push lands in.
    assign pop_ok  = pop & ~empty & ~flush;
    assign push_ok = push & ~flush & (~full | pop_ok);

    always_ff @(posedge clk) begin
        if (!rst && push_ok) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/cocpu_host_mailbox.sv
// Co-CPU to host byte mailbox at I/O2 $DFF8-$DFFB with level interrupt; reads are combinational, pushes visible next cycle.
// Backpressure: co-CPU sees cocpu_full; bytes pushed while full are dropped and flagged as sticky overflow.
module cocpu_host_mailbox
    import cocpu_mailbox_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic       clock_cpu,
    input  logic       reset_cpu,
    input  logic       _io2,
    input  logic       cpu_strobe,
    input  logic       r_w_cpu,
    input  logic [7:0] address_cpu,
    input  logic [7:0] data_cpu_in,
    output logic [7:0] data_cpu_out,
    output logic       data_cpu_oe,
    input  logic       cocpu_wr,
    input  logic [7:0] data_cocpu,
    output logic       cocpu_full,
    output logic       _irq
);

    logic          sel;
    logic          acc;
    logic [1:0]    ofs;
    logic          pop_req;
    logic          ctrl_wr;
    logic          flush;
    logic          clr_ovf;
    logic          ovf_set;
    logic          overflow;
    logic          irq_en;
    logic          irq_out;
    logic [7:0]    head_dat;
    logic [AW:0]   count;
    logic [4:0]    count_field;
    logic          full;
    logic          empty;
    logic          ctrl_unused;

    assign sel     = ~_io2 & (address_cpu[7:2] == WIN_BASE);
    assign acc     = sel & cpu_strobe;
    assign ofs     = address_cpu[1:0];
    assign pop_req = acc & r_w_cpu & (ofs == OFS_DATA);
    assign ctrl_wr = acc & ~r_w_cpu & (ofs == OFS_CONTROL);
    assign flush   = ctrl_wr & data_cpu_in[CTRL_FLUSH];
    assign clr_ovf = ctrl_wr & data_cpu_in[CTRL_CLROVF];
    assign ctrl_unused = ^data_cpu_in[7:3];

    // When full, any DATA read is a real pop, so the push is accepted instead of overflowing.
    assign ovf_set = cocpu_wr & full & ~pop_req & ~flush;

    mailbox_fifo #(.DEPTH(DEPTH), .AW(AW)) u_fifo (
        .clk      (clock_cpu),
        .rst      (reset_cpu),
        .push     (cocpu_wr),
        .push_dat (data_cocpu),
        .pop      (pop_req),
        .flush    (flush),
        .head_dat (head_dat),
        .count    (count),
        .full     (full),
        .empty    (empty)
    );

    always_ff @(posedge clock_cpu) begin
        if (reset_cpu) begin
            overflow <= 1'b0;
            irq_en   <= 1'b0;
        end else begin
            if (ovf_set)      overflow <= 1'b1;
            else if (clr_ovf) overflow <= 1'b0;
            if (ctrl_wr)      irq_en   <= data_cpu_in[CTRL_IRQEN];
        end
    end

    assign irq_out     = irq_en & ~empty;
    assign _irq        = ~irq_out;
    assign cocpu_full  = full;
    assign count_field = 5'(count);
    assign data_cpu_oe = sel & r_w_cpu;

    always_comb begin
        data_cpu_out = 8'h00;
        case (ofs)
            OFS_DATA:    data_cpu_out = empty ? 8'h00 : head_dat;
            OFS_STATUS:  data_cpu_out = {irq_out, overflow, full, count_field};
            OFS_CONTROL: data_cpu_out = {7'b0, irq_en};
            default:     data_cpu_out = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_cocpu_host_mailbox.sv
// Directed self-checking bench for cocpu_host_mailbox with hand-computed register values.
module tb_cocpu_host_mailbox;

    logic       clock_cpu = 1'b0;
    logic       reset_cpu = 1'b0;
    logic       _io2 = 1'b1;
    logic       cpu_strobe = 1'b0;
    logic       r_w_cpu = 1'b1;
    logic [7:0] address_cpu = 8'h00;
    logic [7:0] data_cpu_in = 8'h00;
    logic [7:0] data_cpu_out;
    logic       data_cpu_oe;
    logic       cocpu_wr = 1'b0;
    logic [7:0] data_cocpu = 8'h00;
    logic       cocpu_full;
    logic       _irq;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock_cpu = ~clock_cpu;

    cocpu_host_mailbox #(.DEPTH(16), .AW(4)) dut (
        .clock_cpu    (clock_cpu),
        .reset_cpu    (reset_cpu),
        ._io2         (_io2),
        .cpu_strobe   (cpu_strobe),
        .r_w_cpu      (r_w_cpu),
        .address_cpu  (address_cpu),
        .data_cpu_in  (data_cpu_in),
        .data_cpu_out (data_cpu_out),
        .data_cpu_oe  (data_cpu_oe),
        .cocpu_wr     (cocpu_wr),
        .data_cocpu   (data_cocpu),
        .cocpu_full   (cocpu_full),
        ._irq         (_irq)
    );

    // One clock: optional host access and optional co-CPU push in the same cycle.
    task automatic cycle(input bit acc, input bit rw, input logic [1:0] ofs, input logic [7:0] wd,
                         input bit psh, input logic [7:0] pd, output logic [7:0] rd);
        @(negedge clock_cpu);
        _io2        = ~acc;
        cpu_strobe  = acc;
        r_w_cpu     = rw;
        address_cpu = {6'b111110, ofs};
        data_cpu_in = wd;
        cocpu_wr    = psh;
        data_cocpu  = pd;
        #1 rd = data_cpu_out;
        @(posedge clock_cpu);
        #1;
        _io2       = 1'b1;
        cpu_strobe = 1'b0;
        r_w_cpu    = 1'b1;
        cocpu_wr   = 1'b0;
    endtask

    task automatic rd_reg(input logic [1:0] ofs, output logic [7:0] rd);
        cycle(1'b1, 1'b1, ofs, 8'h00, 1'b0, 8'h00, rd);
    endtask

    task automatic wr_reg(input logic [1:0] ofs, input logic [7:0] wd);
        logic [7:0] dummy;
        cycle(1'b1, 1'b0, ofs, wd, 1'b0, 8'h00, dummy);
    endtask

    task automatic push(input logic [7:0] pd);
        logic [7:0] dummy;
        cycle(1'b0, 1'b1, 2'd0, 8'h00, 1'b1, pd, dummy);
    endtask

    task automatic test_reset;
        logic [7:0] r;
        @(negedge clock_cpu);
        reset_cpu = 1'b1;
        repeat (2) @(negedge clock_cpu);
        reset_cpu = 1'b0;
        #1;
        n_checks++;
        if (_irq !== 1'b1) begin n_fail++; $display("FAIL reset_irq got %b want 1", _irq); end
        n_checks++;
        if (cocpu_full !== 1'b0) begin n_fail++; $display("FAIL reset_full got %b want 0", cocpu_full); end
        rd_reg(2'd1, r);
        n_checks++;
        if (r !== 8'h00) begin n_fail++; $display("FAIL reset_status got %h want 00", r); end
        @(negedge clock_cpu);
        _io2 = 1'b0; address_cpu = 8'hF9; r_w_cpu = 1'b1;
        #1;
        n_checks++;
        if (data_cpu_oe !== 1'b1) begin n_fail++; $display("FAIL oe_read got %b want 1", data_cpu_oe); end
        address_cpu = 8'hF4;
        #1;
        n_checks++;
        if (data_cpu_oe !== 1'b0) begin n_fail++; $display("FAIL oe_outside got %b want 0", data_cpu_oe); end
        _io2 = 1'b1;
    endtask

    task automatic test_basic;
        logic [7:0] r;
        push(8'hA5);
        push(8'h3C);
        rd_reg(2'd1, r);
        n_checks++;
        if (r !== 8'h02) begin n_fail++; $display("FAIL basic_status2 got %h want 02", r); end
        rd_reg(2'd0, r);
        n_checks++;
        if (r !== 8'hA5) begin n_fail++; $display("FAIL basic_data0 got %h want a5", r); end
        rd_reg(2'd0, r);
        n_checks++;
        if (r !== 8'h3C) begin n_fail++; $display("FAIL basic_data1 got %h want 3c", r); end
        rd_reg(2'd1, r);
        n_checks++;
        if (r !== 8'h00) begin n_fail++; $display("FAIL basic_status0 got %h want 00", r); end
        rd_reg(2'd3, r);
        n_checks++;
        if (r !== 8'h00) begin n_fail++; $display("FAIL reserved got %h want 00", r); end
    endtask

    task automatic test_irq;
        logic [7:0] r;
        wr_reg(2'd2, 8'hFF);
        rd_reg(2'd2, r);
        n_checks++;
        if (r !== 8'h01) begin n_fail++; $display("FAIL ctrl_readback got %h want 01", r); end
        wr_reg(2'd2, 8'h01);
        n_checks++;
        if (_irq !== 1'b1) begin n_fail++; $display("FAIL irq_idle got %b want 1", _irq); end
        push(8'h5A);
        n_checks++;
        if (_irq !== 1'b0) begin n_fail++; $display("FAIL irq_after_push got %b want 0", _irq); end
        rd_reg(2'd1, r);
        n_checks++;
        if (r !== 8'h81) begin n_fail++; $display("FAIL irq_status got %h want 81", r); end
        rd_reg(2'd0, r);
        n_checks++;
        if (_irq !== 1'b1) begin n_fail++; $display("FAIL irq_after_pop got %b want 1", _irq); end
        rd_reg(2'd1, r);
        n_checks++;
        if (r !== 8'h00) begin n_fail++; $display("FAIL irq_status_drained got %h want 00", r); end
        wr_reg(2'd2, 8'h00);
    endtask

    task automatic test_overflow;
        logic [7:0] r;
        int bad;
        for (int i = 0; i < 16; i++) push(8'(i));
        n_checks++;
        if (cocpu_full !== 1'b1) begin n_fail++; $display("FAIL ovf_full got %b want 1", cocpu_full); end
        push(8'd16);
        rd_reg(2'd1, r);
        n_checks++;
        if (r !== 8'h70) begin n_fail++; $display("FAIL ovf_status got %h want 70", r); end
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            rd_reg(2'd0, r);
            if (r !== 8'(i)) begin
                bad++;
                $display("FAIL ovf_drain idx %0d got %h want %h", i, r, 8'(i));
            end
        end
        n_checks++;
        if (bad != 0) n_fail++;
        rd_reg(2'd1, r);
        n_checks++;
        if (r !== 8'h40) begin n_fail++; $display("FAIL ovf_sticky got %h want 40", r); end
        wr_reg(2'd2, 8'h04);
        rd_reg(2'd1, r);
        n_checks++;
        if (r !== 8'h00) begin n_fail++; $display("FAIL ovf_clear got %h want 00", r); end
    endtask

    task automatic test_full_push_pop;
        logic [7:0] r;
        int bad;
        for (int i = 0; i < 16; i++) push(8'h20 + 8'(i));
        cycle(1'b1, 1'b1, 2'd0, 8'h00, 1'b1, 8'hEE, r);
        n_checks++;
        if (r !== 8'h20) begin n_fail++; $display("FAIL fullpp_head got %h want 20", r); end
        rd_reg(2'd1, r);
        n_checks++;
        if (r !== 8'h30) begin n_fail++; $display("FAIL fullpp_status got %h want 30", r); end
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            rd_reg(2'd0, r);
            if (r !== ((i == 15) ? 8'hEE : 8'h21 + 8'(i))) begin
                bad++;
                $display("FAIL fullpp_drain idx %0d got %h", i, r);
            end
        end
        n_checks++;
        if (bad != 0) n_fail++;
    endtask

    task automatic test_empty_push_pop;
        logic [7:0] r;
        cycle(1'b1, 1'b1, 2'd0, 8'h00, 1'b1, 8'h11, r);
        n_checks++;
        if (r !== 8'h00) begin n_fail++; $display("FAIL emptypp_read got %h want 00", r); end
        rd_reg(2'd1, r);
        n_checks++;
        if (r !== 8'h01) begin n_fail++; $display("FAIL emptypp_count got %h want 01", r); end
        rd_reg(2'd0, r);
        n_checks++;
        if (r !== 8'h11) begin n_fail++; $display("FAIL emptypp_data got %h want 11", r); end
    endtask

    task automatic test_flush_and_reset;
        logic [7:0] r;
        for (int i = 0; i < 5; i++) push(8'h50 + 8'(i));
        cycle(1'b1, 1'b0, 2'd2, 8'h02, 1'b1, 8'h77, r);
        rd_reg(2'd1, r);
        n_checks++;
        if (r !== 8'h00) begin n_fail++; $display("FAIL flush_status got %h want 00", r); end
        rd_reg(2'd0, r);
        n_checks++;
        if (r !== 8'h00) begin n_fail++; $display("FAIL flush_data got %h want 00", r); end
        // Overflow set beats a same-cycle clear; flush alone leaves overflow alone.
        for (int i = 0; i < 16; i++) push(8'(i));
        cycle(1'b1, 1'b0, 2'd2, 8'h04, 1'b1, 8'h99, r);
        rd_reg(2'd1, r);
        n_checks++;
        if (r !== 8'h70) begin n_fail++; $display("FAIL setwins_status got %h want 70", r); end
        wr_reg(2'd2, 8'h02);
        rd_reg(2'd1, r);
        n_checks++;
        if (r !== 8'h40) begin n_fail++; $display("FAIL flush_keeps_ovf got %h want 40", r); end
        wr_reg(2'd2, 8'h05);
        for (int i = 0; i < 3; i++) push(8'hC0 + 8'(i));
        n_checks++;
        if (_irq !== 1'b0) begin n_fail++; $display("FAIL pre_reset_irq got %b want 0", _irq); end
        reset_cpu = 1'b1;
        cycle(1'b1, 1'b1, 2'd0, 8'h00, 1'b1, 8'hDD, r);
        reset_cpu = 1'b0;
        n_checks++;
        if (_irq !== 1'b1) begin n_fail++; $display("FAIL midreset_irq got %b want 1", _irq); end
        rd_reg(2'd1, r);
        n_checks++;
        if (r !== 8'h00) begin n_fail++; $display("FAIL midreset_status got %h want 00", r); end
        rd_reg(2'd2, r);
        n_checks++;
        if (r !== 8'h00) begin n_fail++; $display("FAIL midreset_ctrl got %h want 00", r); end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_irq;
        test_overflow;
        test_full_push_pop;
        test_empty_push_pop;
        test_flush_and_reset;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cocpu_host_mailbox.md
Name: cocpu_host_mailbox

Overview:
- Co-CPU to host message channel: the co-CPU pushes bytes into a FIFO; the host CPU drains them through a 4-byte register window in I/O2 at $DFF8-$DFFB.
- Raises an active-low host interrupt while data is waiting.
- Complements the host-to-cartridge bank/reset registers at $DFFC-$DFFF, so the co-CPU can report completion, results and errors back to the C64.
- Single clock domain: all inputs are synchronous to clock_cpu.

Parameters:
- DEPTH, 16, FIFO entries; power of two, 2..16.
- AW, 4, log2(DEPTH); the count field is AW+1 bits.

Ports:
- clock_cpu  in  1  system clock; all state updates on the rising edge.
- reset_cpu  in  1  synchronous, active-high reset.
- _io2  in  1  host I/O2 select, active low.
- cpu_strobe  in  1  one-cycle qualifier: exactly one cycle per host bus access.
- r_w_cpu  in  1  host direction: 1 = read, 0 = write.
- address_cpu  in  8  host address low byte.
- data_cpu_in  in  8  host write data.
- data_cpu_out  out  8  host read data.
- data_cpu_oe  out  1  high when this block drives the host data bus.
- cocpu_wr  in  1  co-CPU push strobe, one cycle per byte.
- data_cocpu  in  8  co-CPU push data.
- cocpu_full  out  1  FIFO full; visible to the co-CPU as a status bit.
- _irq  out  1  host interrupt, active low.

Behaviour:
- Decode:
  - sel = !_io2 & address_cpu[7:2]==6'b111110.
  - A host access is sel & cpu_strobe. Register offset = address_cpu[1:0].
- Register map:
  - 0 DATA (R): FIFO head (first-word fall-through). A read pops one entry. Reading while empty returns 8'h00 and does not pop. Writes are ignored.
  - 1 STATUS (R): bit7 irq_out, bit6 overflow, bit5 full, bits4:0 count (zero-extended). Writes are ignored.
  - 2 CONTROL (R/W): bit0 irq_en. Bit1 flush: write-1 self-clearing, reads 0. Bit2 clr_ovf: write-1 self-clearing, reads 0. Bits7:3 read 0.
  - 3 RESERVED: reads 8'h00, writes ignored.
- Read path: data_cpu_out is combinational from the offset. data_cpu_oe = sel & r_w_cpu (independent of cpu_strobe).
- Push:
  - cocpu_wr & !full: write data_cocpu at wr_ptr, then wr_ptr+1 (wraps modulo DEPTH) and count+1.
  - cocpu_wr & full: byte dropped, overflow<=1 (sticky).
- Pop: DATA read & count!=0: rd_ptr+1 (wraps modulo DEPTH), count-1.
- Simultaneous push and pop:
  - count != 0: both take effect and count is unchanged.
  - Full: push accepted because the pop frees a slot; count stays DEPTH and overflow is not set.
  - Empty: the pop is ignored (returns 00) and the push is accepted; count becomes 1.
- Flush (CONTROL write with bit1=1):
  - Same cycle: wr_ptr, rd_ptr and count go to 0.
  - A concurrent push is dropped without setting overflow.
  - overflow is unaffected unless bit2 is also set.
- clr_ovf and a same-cycle overflow event: set wins, so overflow stays 1.
- Full flag: full = (count==DEPTH), registered-derived. cocpu_full = full.
- IRQ:
  - _irq = !(irq_en & count!=0). It is level-sensitive and needs no ack; draining the FIFO releases it.
  - Latency: push at edge N gives _irq low after edge N (the same cycle in which count updates).
- Reset: ptrs, count, overflow and irq_en go to 0, so _irq=1 and cocpu_full=0. FIFO storage is not cleared.
- A reset asserted during a pending access wins over every other update.
- Latency: written data is readable at DATA on the cycle after the push edge.

Decomposition:
- Package cocpu_mailbox_pkg holds:
  - Offset constants OFS_DATA=0, OFS_STATUS=1, OFS_CONTROL=2.
  - Window base 6'b111110.
  - STATUS bit positions (IRQ=7, OVF=6, FULL=5) and CONTROL bit positions (IRQEN=0, FLUSH=1, CLROVF=2).
- Sub-module mailbox_fifo: a synchronous DEPTH x 8 FWFT FIFO with push, pop, flush, count, full and empty. The register decode, overflow and IRQ logic stay in the top.

Test Plan:
- Reset, then push 8'hA5 and 8'h3C. STATUS reads 8'h02. Read DATA twice -> A5 then 3C. STATUS then reads 8'h00.
- CONTROL=8'h01, then push one byte -> _irq=0 the cycle after the push. Pop it -> _irq=1 and STATUS bit7=0.
- Push 17 bytes 0..16 with DEPTH=16:
  - cocpu_full=1 after 16 pushes; STATUS=8'h70 (ovf, full, count 16 -> bits4:0=0x10 requires 5 bits, so check STATUS=8'h70).
  - Drain returns 0..15; byte 16 is lost.
  - CONTROL=8'h04 clears ovf.
- Full FIFO, same-cycle push 8'hEE and DATA read -> count stays 16, overflow stays 0, and 8'hEE is the last byte drained.
- Empty FIFO, same-cycle push 8'h11 and DATA read -> read returns 00, count=1, next read returns 11.
- 5 bytes queued, then a CONTROL write of 8'h02 together with a push -> count=0, DATA reads 00, overflow=0. Asserting reset_cpu mid-stream with irq_en=1 -> _irq=1 and STATUS=00 next cycle.
